// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline hazard unit for the 5-stage core.
//   Compares register numbers across D/E/M/W, produces per-operand forwarding
//   selects, load-use and PC-write stalls, branch flushes, and runs a small
//   FSM that holds E for MC_LAT cycles on multi-cycle ops while bubbling M.
//   Keeps a saturating count of cycles in which D was stalled.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   SrcD/SrcValidD               D-stage source regs (packed NSRC x RADDR) + used bits
//   SrcE/SrcValidE               E-stage source regs + used bits
//   DstE/M/W, RegWriteE/M/W      per-stage destination regs + per-dest write enables
//   MemToRegE                    E-stage instruction is a load (dest 0)
//   PCSrcD/E/M/W, BranchTakenE   PC-write pending per stage, taken branch in E
//   MultiCycleE                  E holds a condition-passed multi-cycle op
//   ForwardE                     2 bits/operand: 00 regfile, 01 ResultW, 10 ALUOutM
//   StallF/D/E, FlushD/E/M       pipeline register hold / clear
//   McBusy, McDone               multi-cycle FSM busy / final E cycle
//   StallCnt                     saturating StallD cycle count

// Per-operand forwarding select. M beats W; PC is never forwarded.
module hazard_fwd_lane #(
  parameter int RADDR  = 4,
  parameter int NDST   = 2,
  parameter int PC_REG = 15
) (
  input  logic [RADDR-1:0]      src,
  input  logic                  src_valid,
  input  logic [NDST*RADDR-1:0] dst_m,
  input  logic [NDST-1:0]       we_m,
  input  logic [NDST*RADDR-1:0] dst_w,
  input  logic [NDST-1:0]       we_w,
  output logic [1:0]            fwd
);
  logic hit_m, hit_w;

  always_comb begin
    hit_m = 1'b0;
    hit_w = 1'b0;
    // Any matching dest selects the same M/W bus, so multiple hits are harmless.
    for (int k = 0; k < NDST; k++) begin
      hit_m = hit_m | (we_m[k] && (dst_m[k*RADDR +: RADDR] == src));
      hit_w = hit_w | (we_w[k] && (dst_w[k*RADDR +: RADDR] == src));
    end
    fwd = 2'b00;
    if (src_valid && (src != RADDR'(PC_REG))) begin
      if (hit_m)      fwd = 2'b10;
      else if (hit_w) fwd = 2'b01;
    end
  end
endmodule

module hazard_scoreboard #(
  parameter int RADDR  = 4,
  parameter int NSRC   = 3,
  parameter int NDST   = 2,
  parameter int MC_LAT = 4,
  parameter int PC_REG = 15,
  parameter int CNTW   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC*RADDR-1:0] SrcD,
  input  logic [NSRC-1:0]       SrcValidD,
  input  logic [NSRC*RADDR-1:0] SrcE,
  input  logic [NSRC-1:0]       SrcValidE,
  input  logic [NDST*RADDR-1:0] DstE,
  input  logic [NDST*RADDR-1:0] DstM,
  input  logic [NDST*RADDR-1:0] DstW,
  input  logic [NDST-1:0]       RegWriteE,
  input  logic [NDST-1:0]       RegWriteM,
  input  logic [NDST-1:0]       RegWriteW,
  input  logic                  MemToRegE,
  input  logic                  PCSrcD,
  input  logic                  PCSrcE,
  input  logic                  PCSrcM,
  input  logic                  PCSrcW,
  input  logic                  BranchTakenE,
  input  logic                  MultiCycleE,
  output logic [2*NSRC-1:0]     ForwardE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  McBusy,
  output logic                  McDone,
  output logic [CNTW-1:0]       StallCnt
);
  // Holds MC_LAT-2 (max 14 for MC_LAT=16).
  localparam int CW = $clog2(MC_LAT);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mc_state_t;

  mc_state_t            state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 mcstall, mc_done;
  logic                 ldrstall, ld_hit, pc_wr_pend;
  logic [NSRC-1:0][1:0] fwd;

  // ---- forwarding, one lane per source operand ----
  for (genvar i = 0; i < NSRC; i++) begin : g_lane
    hazard_fwd_lane #(.RADDR(RADDR), .NDST(NDST), .PC_REG(PC_REG)) u_lane (
      .src       (SrcE[i*RADDR +: RADDR]),
      .src_valid (SrcValidE[i]),
      .dst_m     (DstM),
      .we_m      (RegWriteM),
      .dst_w     (DstW),
      .we_w      (RegWriteW),
      .fwd       (fwd[i])
    );
  end

  // ---- load-use: only dest 0 is written by a load ----
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < NSRC; i++)
      ld_hit = ld_hit | (SrcValidD[i] && (SrcD[i*RADDR +: RADDR] == DstE[RADDR-1:0]));
  end

  assign ldrstall   = !reset && MemToRegE && RegWriteE[0] && ld_hit;
  assign pc_wr_pend = !reset && (PCSrcD || PCSrcE || PCSrcM);

  // ---- multi-cycle execute FSM ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mcstall   = 1'b0;
    mc_done   = 1'b0;
    case (state)
      IDLE: if (MultiCycleE) begin
        // Acceptance cycle already counts as the first E cycle.
        state_nxt = BUSY;
        cnt_nxt   = CW'(MC_LAT - 2);
        mcstall   = 1'b1;
      end
      BUSY: if (cnt != '0) begin
        cnt_nxt = cnt - CW'(1);
        mcstall = 1'b1;
      end else begin
        // Final E cycle: release E so the op moves to M at the next edge.
        mc_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      mcstall = 1'b0;
      mc_done = 1'b0;
    end
  end

  // ---- outputs ----
  assign ForwardE = reset ? '0 : fwd;
  assign StallF   = ldrstall | pc_wr_pend | mcstall;
  assign StallD   = ldrstall | mcstall;
  assign StallE   = mcstall;
  assign FlushM   = reset | mcstall;
  assign FlushD   = reset | pc_wr_pend | PCSrcW | BranchTakenE;
  // A held E must not be cleared; a branch that collides with mcstall
  // is still visible through FlushD.
  assign FlushE   = reset | ((ldrstall | BranchTakenE) & !mcstall);
  assign McBusy   = (state == BUSY) && !reset;
  assign McDone   = mc_done;

  // ---- saturating stall-cycle counter ----
  always_ff @(posedge clk) begin
    if (reset)                        StallCnt <= '0;
    else if (StallD && StallCnt != '1) StallCnt <= StallCnt + CNTW'(1);
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard unit of the 5-stage ARM core.
- Compares register numbers itself instead of taking precomputed match bits, and supports a configurable number of source and destination operands (long multiply: RdLo/RdHi).
- Adds a multi-cycle execute FSM that holds E for MC_LAT cycles and bubbles M.
- Keeps a saturating stall-cycle performance counter.
- Sits beside controller/datapath and drives their forward, stall and flush inputs.

Parameters:
- RADDR, 4, register-number width.
- NSRC, 3, source operands per instruction (Rn, Rm, Rs/Ra).
- NDST, 2, destination ports per instruction (index 0 = primary Rd/RdLo).
- MC_LAT, 4, total E-stage cycles of a multi-cycle op; legal range 2..16.
- PC_REG, 15, register number that is never forwarded.
- CNTW, 16, stall-counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- SrcD  in  NSRC*RADDR  D-stage source register numbers, operand i at [i*RADDR +: RADDR]
- SrcValidD  in  NSRC  D-stage source used
- SrcE  in  NSRC*RADDR  E-stage source register numbers
- SrcValidE  in  NSRC  E-stage source used
- DstE / DstM / DstW  in  NDST*RADDR each  destination register numbers per stage
- RegWriteE / RegWriteM / RegWriteW  in  NDST each  per-destination write enable
- MemToRegE  in  1  E-stage instruction is a load
- PCSrcD / PCSrcE / PCSrcM / PCSrcW  in  1 each  instruction writes PC
- BranchTakenE  in  1  branch resolved taken in E
- MultiCycleE  in  1  E holds a condition-passed multi-cycle op
- ForwardE  out  2*NSRC  per-operand select: 00 regfile, 01 ResultW, 10 ALUOutM
- StallF / StallD / StallE  out  1 each  hold pipeline register
- FlushD / FlushE / FlushM  out  1 each  clear pipeline register (bubble)
- McBusy  out  1  multi-cycle FSM in BUSY
- McDone  out  1  final E cycle of a multi-cycle op
- StallCnt  out  CNTW  saturating count of cycles with StallD=1

Behaviour:
- Reset is synchronous. On reset: FSM=IDLE, cnt=0, StallCnt=0.
- While reset is high: all stalls 0, FlushD=FlushE=FlushM=1, ForwardE=0, McBusy=McDone=0.
- Forwarding (combinational, per operand i):
  - Match against M is SrcValidE[i] & RegWriteM[k] & SrcE_i==DstM_k for any k; same rule for W.
  - M has priority over W (10 over 01).
  - A source equal to PC_REG always selects 00.
  - If two M destinations match (illegal), use k=0.
- Load-use: ldrstall = MemToRegE & RegWriteE[0] & any valid SrcD_i==DstE_0. Only dest 0 is load-written.
- Branch and PC-write pending: PCWrPend = PCSrcD | PCSrcE | PCSrcM.
- Multi-cycle FSM:
  - IDLE & MultiCycleE & !reset: go to BUSY, cnt <= MC_LAT-2. Acceptance cycle asserts mcstall.
  - BUSY & cnt!=0: cnt <= cnt-1; mcstall=1.
  - BUSY & cnt==0: McDone=1, mcstall=0, go to IDLE. The instruction advances to M at the next edge.
  - MultiCycleE while BUSY is ignored, since it is the same instruction.
  - For MC_LAT=2 the acceptance cycle loads cnt=0, giving exactly 2 E cycles.
  - McBusy = (state==BUSY).
- Output equations:
  - StallF = ldrstall | PCWrPend | mcstall
  - StallD = ldrstall | mcstall
  - StallE = mcstall
  - FlushM = mcstall (bubble into M while E holds)
  - FlushD = PCWrPend | PCSrcW | BranchTakenE
  - FlushE = (ldrstall | BranchTakenE) & !mcstall
- Flush dominates stall on the same register; the datapath clears.
- BranchTakenE cannot coincide with mcstall. If it does, mcstall wins and BranchTakenE is reported only via FlushD.
- StallCnt increments on each cycle with StallD=1 and saturates at 2^CNTW-1 (no wrap).
- Reset mid-BUSY returns the FSM to IDLE at the next edge. The E instruction is flushed by the reset flushes.
- All outputs except StallCnt, McBusy and the FSM state are combinational, with zero latency.

Test Plan:
- Forward priority: SrcE_0=3, DstM_0=3 & RegWriteM=01, DstW_0=3 & RegWriteW=01 -> ForwardE[1:0]=10. Drop the M write -> 01. Set SrcE_0=15 -> 00.
- Long-multiply dest: SrcE_1=5, DstM_1=5, RegWriteM=10 -> ForwardE[3:2]=10. Clear SrcValidE[1] -> 00.
- Load-use: MemToRegE=1, DstE_0=2, RegWriteE=01, SrcD_0=2 valid -> StallF=StallD=FlushE=1 for one cycle, StallCnt +1.
- Multi-cycle, MC_LAT=4: pulse MultiCycleE at cycle 0 and hold -> StallE=FlushM=1 cycles 0-2, McDone=1 cycle 3, McBusy=1 cycles 1-3, StallCnt +3. With MC_LAT=2 -> one stall cycle, then McDone.
- Branch: BranchTakenE=1 -> FlushD=FlushE=1, no stalls. PCSrcD=1 -> StallF=FlushD=1, StallD=0.
- Reset during BUSY at cycle 1 -> FSM IDLE and McBusy=0 after the edge, StallCnt=0. Separately, force 2^CNTW+5 stall cycles (CNTW=4) -> StallCnt holds at 15.
